// File: rtl/ariane_pkg.sv
// Shared decode/issue types: the scoreboard entry carried through the
// decode-to-issue queue, and that queue's default depth.
package ariane_pkg;

  localparam int unsigned DECODE_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
  } scoreboard_entry_t;

endpackage

// File: rtl/decode_issue_queue.sv
// Decoupling queue between decode and issue, with control-flow gating.
// Optional zero-latency bypass of an empty queue: define DECODE_QUEUE_BYPASS_EN.
module decode_issue_queue
  import ariane_pkg::*;
#(
  parameter  int unsigned DEPTH = DECODE_QUEUE_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  scoreboard_entry_t instr_i,
  input  logic              instr_valid_i,
  input  logic              is_ctrl_flow_i,
  output logic              instr_ready_o,
  output scoreboard_entry_t issue_instr_o,
  output logic              issue_valid_o,
  output logic              is_ctrl_flow_o,
  input  logic              issue_ack_i,
  input  logic              resolve_branch_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_cf;
  } dq_entry_t;

  typedef enum logic {IDLE, PENDING} gate_state_e;

  dq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  gate_state_e      r_state;

  dq_entry_t w_head;
  logic      w_empty, w_have, w_byp, w_push, w_pop, w_pop_q, w_wr;

  assign w_empty       = (r_count == '0);
  // Ready depends on occupancy alone so there is no ack->ready path.
  assign instr_ready_o = (r_count < CNT_W'(DEPTH));
  assign w_push        = instr_valid_i & instr_ready_o;

`ifdef DECODE_QUEUE_BYPASS_EN
  assign w_byp = w_empty & ~flush_i;
`else
  assign w_byp = 1'b0;
`endif

  assign w_head  = w_byp ? dq_entry_t'{sbe: instr_i, is_cf: is_ctrl_flow_i}
                         : r_mem[r_rd_ptr];
  assign w_have  = w_byp ? instr_valid_i : ~w_empty;

  assign issue_instr_o  = w_head.sbe;
  assign is_ctrl_flow_o = w_head.is_cf;
  assign issue_valid_o  = w_have & ~(w_head.is_cf & (r_state == PENDING));
  assign count_o        = r_count;
  assign empty_o        = w_empty;

  assign w_pop   = issue_valid_o & issue_ack_i;
  assign w_pop_q = w_pop & ~w_byp;
  // A bypassed entry consumed in the same cycle never needs a slot.
  assign w_wr    = w_push & ~(w_byp & w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= dq_entry_t'{sbe: instr_i, is_cf: is_ctrl_flow_i};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_q) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_pop_q})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A resolve seen while a younger branch issues belongs to the older one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else if (flush_i) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_pop && w_head.is_cf) r_state <= PENDING;
        PENDING: if (w_pop && w_head.is_cf) r_state <= PENDING;
                 else if (resolve_branch_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
